// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one line-wide memory port between the I-cache miss path
//            and the D-cache miss/write-back path, with alternating tie priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LINE_SIZE = 64,
  parameter int LATENCY   = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic [LINE_SIZE-1:0] i_rdata,
  input  logic                 d_req_read,
  input  logic                 d_req_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [LINE_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [LINE_SIZE-1:0] d_rdata,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [LINE_SIZE-1:0] m_wdata,
  input  logic [LINE_SIZE-1:0] m_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] c_last_cnt = 4'(LATENCY - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic                  r_owner_d;       // 1: D side owns the port
  logic                  r_op_write;
  logic                  r_last_grant_d;  // 1: D was granted last
  logic [WORD_SIZE-1:0]  r_addr;
  logic [LINE_SIZE-1:0]  r_wdata;
  logic [LINE_SIZE-1:0]  r_i_rdata;
  logic [LINE_SIZE-1:0]  r_d_rdata;

  logic                  w_d_pend;
  logic                  w_any_req;
  logic                  w_grant_d;

  assign w_d_pend  = d_req_read | d_req_write;
  assign w_any_req = i_req | w_d_pend;
  // On a tie the side that was not granted last wins.
  assign w_grant_d = w_d_pend & (~i_req | ~r_last_grant_d);

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_state_next = ST_ACCESS;
      ST_ACCESS: if (r_cnt == c_last_cnt) w_state_next = ST_RESP;
      ST_RESP:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_cnt          <= 4'd0;
      r_owner_d      <= 1'b0;
      r_op_write     <= 1'b0;
      r_last_grant_d <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner_d      <= w_grant_d;
            r_last_grant_d <= w_grant_d;
            r_cnt          <= 4'd0;
            r_addr         <= w_grant_d ? d_addr : i_addr;
            // Write wins when both D strobes are raised together.
            r_op_write     <= w_grant_d & d_req_write;
            if (w_grant_d && d_req_write) begin
              r_wdata <= d_wdata;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == c_last_cnt && !r_op_write) begin
            if (r_owner_d) begin
              r_d_rdata <= m_rdata;
            end else begin
              r_i_rdata <= m_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign m_readM   = (r_state == ST_ACCESS) & ~r_op_write;
  assign m_writeM  = (r_state == ST_ACCESS) &  r_op_write;
  assign m_address = r_addr;
  assign m_wdata   = r_wdata;
  assign i_ready   = (r_state == ST_RESP) & ~r_owner_d;
  assign d_ready   = (r_state == ST_RESP) &  r_owner_d;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scoreboard bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LAT = 4;
  localparam logic [63:0] c_garbage = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_ready;
  logic [63:0] i_rdata;
  logic        d_req_read = 1'b0;
  logic        d_req_write = 1'b0;
  logic [15:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_ready;
  logic [63:0] d_rdata;
  logic        m_readM;
  logic        m_writeM;
  logic [15:0] m_address;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata = c_garbage;
  logic        busy;

  mem_port_arbiter #(.WORD_SIZE(16), .LINE_SIZE(64), .LATENCY(LAT)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  initial forever #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } acc_t;

  typedef struct {
    bit          side;   // 0: I, 1: D
    int          at;
    logic [63:0] i_rd;
    logic [63:0] d_rd;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int n_vec = 0;
  int n_fail = 0;
  logic [63:0] mdl_i = '0;
  logic [63:0] mdl_d = '0;

  // Memory model and per-cycle command checker.
  int acc_n = 0;
  always @(negedge Clk) begin
    if (!Reset_N) begin
      acc_n = 0;
      m_rdata = c_garbage;
    end else if (m_readM || m_writeM) begin
      acc_n++;
      n_vec++;
      if (exp_acc.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_access: got addr %h rd %b wr %b, required no access", m_address, m_readM, m_writeM);
        m_rdata = c_garbage;
      end else begin
        if (m_readM != !exp_acc[0].wr || m_writeM != exp_acc[0].wr || m_address != exp_acc[0].addr ||
            (exp_acc[0].wr && m_wdata != exp_acc[0].wdata) || !busy) begin
          n_fail++;
          $display("FAIL access_cmd: got rd %b wr %b addr %h wdata %h busy %b, required wr %b addr %h wdata %h busy 1",
                   m_readM, m_writeM, m_address, m_wdata, busy, exp_acc[0].wr, exp_acc[0].addr, exp_acc[0].wdata);
        end
        m_rdata = (acc_n == LAT) ? exp_acc[0].rdata : c_garbage;
      end
    end else begin
      if (acc_n != 0) begin
        n_vec++;
        if (acc_n != LAT) begin
          n_fail++;
          $display("FAIL access_len: got %0d cycles, required %0d", acc_n, LAT);
        end
        if (exp_acc.size() > 0) void'(exp_acc.pop_front());
        acc_n = 0;
      end
      m_rdata = c_garbage;
    end
  end

  // Response monitor.
  always @(negedge Clk) begin
    if (Reset_N && (i_ready || d_ready)) begin
      n_vec++;
      if (exp_rsp.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ready: got i_ready %b d_ready %b at cycle %0d, required none", i_ready, d_ready, cyc);
      end else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        if (i_ready != !r.side || d_ready != r.side || cyc != r.at ||
            i_rdata != r.i_rd || d_rdata != r.d_rd || !busy) begin
          n_fail++;
          $display("FAIL response: got i_rdy %b d_rdy %b cyc %0d i_rdata %h d_rdata %h busy %b, required side %0d cyc %0d i_rdata %h d_rdata %h",
                   i_ready, d_ready, cyc, i_rdata, d_rdata, busy, r.side, r.at, r.i_rd, r.d_rd);
        end
      end
    end
  end

  task automatic push_acc(input bit wr, input logic [15:0] a, input logic [63:0] wd, input logic [63:0] rd);
    acc_t x;
    x.wr = wr; x.addr = a; x.wdata = wd; x.rdata = rd;
    exp_acc.push_back(x);
  endtask

  task automatic push_rsp(input bit side, input int at, input bit wr, input logic [63:0] rd);
    rsp_t x;
    if (!wr) begin
      if (side) mdl_d = rd; else mdl_i = rd;
    end
    x.side = side; x.at = at; x.i_rd = mdl_i; x.d_rd = mdl_d;
    exp_rsp.push_back(x);
  endtask

  task automatic wait_for(input bit side);
    bit got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (side ? d_ready : i_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_fail++;
      $display("FAIL ready_timeout: got no %s ready in 60 cycles, required a pulse", side ? "D" : "I");
    end
    @(posedge Clk); #1;
  endtask

  task automatic i_read(input logic [15:0] a);
    i_addr = a;
    i_req = 1'b1;
    wait_for(1'b0);
    i_req = 1'b0;
  endtask

  task automatic d_op(input bit rd, input bit wr, input logic [15:0] a, input logic [63:0] wd);
    d_addr = a; d_wdata = wd;
    d_req_read = rd; d_req_write = wr;
    wait_for(1'b1);
    d_req_read = 1'b0; d_req_write = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if ({i_ready, d_ready, m_readM, m_writeM, busy} != 5'b0 || m_address != '0 ||
        m_wdata != '0 || i_rdata != '0 || d_rdata != '0) begin
      n_fail++;
      $display("FAIL %s: got rdy %b%b rdM %b wrM %b busy %b addr %h wdata %h i_rd %h d_rd %h, required all 0",
               tag, i_ready, d_ready, m_readM, m_writeM, busy, m_address, m_wdata, i_rdata, d_rdata);
    end
  endtask

  task automatic do_reset();
    Reset_N = 1'b0;
    exp_acc.delete();
    exp_rsp.delete();
    mdl_i = '0; mdl_d = '0;
    @(posedge Clk); #1;
    check_zero("reset_state");
    Reset_N = 1'b1;
    @(posedge Clk); #1;
  endtask

  int t0;
  initial begin
    #1;
    do_reset();

    // Plain I read.
    t0 = cyc;
    push_acc(1'b0, 16'h0010, 64'h0, 64'h1111_2222_3333_4444);
    push_rsp(1'b0, t0 + 5, 1'b0, 64'h1111_2222_3333_4444);
    i_read(16'h0010);

    // D write leaves d_rdata alone.
    t0 = cyc;
    push_acc(1'b1, 16'h0200, 64'hAAAA_5555_AAAA_5555, 64'h0);
    push_rsp(1'b1, t0 + 5, 1'b1, 64'h0);
    d_op(1'b0, 1'b1, 16'h0200, 64'hAAAA_5555_AAAA_5555);

    // Address change mid-access is ignored.
    t0 = cyc;
    push_acc(1'b0, 16'h0010, 64'h0, 64'h0123_4567_89AB_CDEF);
    push_rsp(1'b0, t0 + 5, 1'b0, 64'h0123_4567_89AB_CDEF);
    fork
      i_read(16'h0010);
      begin
        @(posedge Clk); @(posedge Clk); #1;
        i_addr = 16'h0020;
      end
    join

    // First tie after reset goes to D, then I.
    do_reset();
    t0 = cyc;
    push_acc(1'b0, 16'h0100, 64'h0, 64'hD0D0_D0D0_0000_0001);
    push_acc(1'b0, 16'h0110, 64'h0, 64'h1E1E_1E1E_0000_0002);
    push_rsp(1'b1, t0 + 5,  1'b0, 64'hD0D0_D0D0_0000_0001);
    push_rsp(1'b0, t0 + 11, 1'b0, 64'h1E1E_1E1E_0000_0002);
    fork
      i_read(16'h0110);
      d_op(1'b1, 1'b0, 16'h0100, 64'h0);
    join

    // D write makes D the last grant; the next tie then goes to I.
    t0 = cyc;
    push_acc(1'b1, 16'h0210, 64'h5A5A_5A5A_A5A5_A5A5, 64'h0);
    push_rsp(1'b1, t0 + 5, 1'b1, 64'h0);
    d_op(1'b0, 1'b1, 16'h0210, 64'h5A5A_5A5A_A5A5_A5A5);

    t0 = cyc;
    push_acc(1'b0, 16'h0120, 64'h0, 64'h1E1E_0000_0000_0003);
    push_acc(1'b0, 16'h0130, 64'h0, 64'hD0D0_0000_0000_0004);
    push_rsp(1'b0, t0 + 5,  1'b0, 64'h1E1E_0000_0000_0003);
    push_rsp(1'b1, t0 + 11, 1'b0, 64'hD0D0_0000_0000_0004);
    fork
      i_read(16'h0120);
      d_op(1'b1, 1'b0, 16'h0130, 64'h0);
    join

    // Read and write raised together: write wins.
    t0 = cyc;
    push_acc(1'b1, 16'h0300, 64'hCAFE_BABE_DEAD_BEEF, 64'h0);
    push_rsp(1'b1, t0 + 5, 1'b1, 64'h0);
    d_op(1'b1, 1'b1, 16'h0300, 64'hCAFE_BABE_DEAD_BEEF);

    // Reset in ACCESS cycle 2 drops the access; a fresh one follows.
    push_acc(1'b0, 16'h0040, 64'h0, 64'h0);
    i_addr = 16'h0040;
    i_req = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset_N = 1'b0;
    #1;
    check_zero("reset_mid_access");
    exp_acc.delete();
    mdl_i = '0; mdl_d = '0;
    @(posedge Clk); #1;
    check_zero("reset_held");
    Reset_N = 1'b1;
    t0 = cyc;
    push_acc(1'b0, 16'h0040, 64'h0, 64'h7777_8888_9999_AAAA);
    push_rsp(1'b0, t0 + 5, 1'b0, 64'h7777_8888_9999_AAAA);
    wait_for(1'b0);
    i_req = 1'b0;

    repeat (5) @(posedge Clk);
    #1;
    n_vec++;
    if (exp_acc.size() != 0 || exp_rsp.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d accesses %0d responses pending, required 0 0", exp_acc.size(), exp_rsp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
